// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the state encoding, the counter-width helper and the STOP_BITS limits.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // A 2-cycle bit still needs one counter bit; $clog2(2) alone would give 1 as well,
    // but $clog2(1) would give 0, so clamp to at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the final cycle.
// o_pre_tick marks the cycle before the final one so callers can register a last-cycle pulse.
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick,
    output logic o_pre_tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_bit_tick = i_enable && (r_cnt == LAST_CNT);
    assign o_pre_tick = i_enable && (r_cnt == PRE_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous FIFO and serialises them as UART frames:
// start, data LSB first, optional even parity, then one or two stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_tx_en,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam bit TWO_STOP = (STOP_BITS >= STOP_BITS_MAX);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    state_t                r_state;
    logic                  r_tx;
    logic                  r_rd_en;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic [IW-1:0]         r_bit_idx;
    logic                  r_stop_idx;

    logic                  w_counting;
    logic                  w_bit_tick;
    logic                  w_pre_tick;
    logic                  w_last_stop;
    logic                  w_can_fetch;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_counting   = (r_state == START) || (r_state == DATA) ||
                          (r_state == PARITY) || (r_state == STOP);
    assign w_last_stop  = !TWO_STOP || r_stop_idx;
    assign w_can_fetch  = i_tx_en && !i_fifo_empty;
    assign w_shift_next = r_shift >> 1;

    // The timer is held at zero outside the serial phases so every START begins a full bit.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (!w_counting),
        .i_enable   (w_counting),
        .o_bit_tick (w_bit_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_tx         <= 1'b1;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_can_fetch) begin
                        r_state <= FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_shift    <= i_fifo_data;
                    r_parity   <= ^i_fifo_data;
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_tx       <= 1'b0;
                    r_state    <= START;
                end
                START: begin
                    if (w_bit_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        r_shift <= w_shift_next;
                        if (r_bit_idx == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IW'(1);
                            r_tx      <= w_shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    // Registered pulse lands in the final cycle of the last stop bit.
                    if (w_pre_tick && w_last_stop) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_bit_tick) begin
                        if (!w_last_stop) begin
                            r_stop_idx <= 1'b1;
                        end else if (w_can_fetch) begin
                            r_state <= FETCH;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_rd_en = r_rd_en;
    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) fed by FIFO models;
// every frame is compared cycle by cycle against a waveform built from the framing rules.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tx_en;
    logic       tx_w    [2];
    logic       rd_w    [2];
    logic       busy_w  [2];
    logic       fd_w    [2];
    logic       empty_w [2];
    logic [7:0] fdata   [2];
    logic [7:0] mem     [2][256];
    int         pushed  [2] = '{0, 0};
    int         popped  [2] = '{0, 0};
    int         rd_cnt  [2] = '{0, 0};
    bit         underflow [2] = '{1'b0, 1'b0};
    int         n_tests = 0;
    int         n_fail  = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(empty_w[0]),
        .i_fifo_data(fdata[0]), .o_fifo_rd_en(rd_w[0]), .o_tx(tx_w[0]),
        .o_busy(busy_w[0]), .o_frame_done(fd_w[0]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(empty_w[1]),
        .i_fifo_data(fdata[1]), .o_fifo_rd_en(rd_w[1]), .o_tx(tx_w[1]),
        .o_busy(busy_w[1]), .o_frame_done(fd_w[1]));

    assign empty_w[0] = (pushed[0] == popped[0]);
    assign empty_w[1] = (pushed[1] == popped[1]);

    // FIFO read port: data_out registered, valid the cycle after the read strobe.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_w[d] === 1'b1 && pushed[d] != popped[d]) begin
                fdata[d]  <= mem[d][8'(popped[d])];
                popped[d] <= popped[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_w[d] === 1'b1) begin
                rd_cnt[d] = rd_cnt[d] + 1;
                if (empty_w[d]) underflow[d] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        mem[d][8'(pushed[d])] = b;
        pushed[d] = pushed[d] + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for the start bit, records one frame and compares it with the ideal frame for b.
    task automatic capture(input int d, input logic [7:0] b, input int drop_at, input int rst_at,
                           output int wait_n, output logic busy_wait, output logic par_bit);
        int          len;
        logic [43:0] got_tx, got_fd, got_busy, exp_tx, exp_fd, exp_busy;
        len = (d == 0) ? 10 * CPB : 11 * CPB;
        got_tx = '0; got_fd = '0; got_busy = '0; exp_tx = '0;
        wait_n = 0;
        busy_wait = 1'b1;
        par_bit = 1'bx;
        do begin
            @(negedge clk);
            wait_n++;
            busy_wait &= busy_w[d];
        end while (tx_w[d] !== 1'b0 && wait_n < 300);
        if (tx_w[d] !== 1'b0) begin
            check($sformatf("start_timeout_d%0d", d), {63'd0, tx_w[d]}, 64'd0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            got_tx[i]   = tx_w[d];
            got_fd[i]   = fd_w[d];
            got_busy[i] = busy_w[d];
            if (i == drop_at) tx_en = 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_tx",   {63'd0, tx_w[d]},   64'd1);
                check("rst_busy", {63'd0, busy_w[d]}, 64'd0);
                check("rst_rd",   {63'd0, rd_w[d]},   64'd0);
                check("rst_fd",   {63'd0, fd_w[d]},   64'd0);
                rst_n = 1'b1;
                return;
            end
        end
        for (int i = 0; i < len; i++) begin
            int k;
            k = i / CPB;
            if (k == 0)                exp_tx[i] = 1'b0;
            else if (k <= 8)           exp_tx[i] = b[k-1];
            else if (d == 1 && k == 9) exp_tx[i] = ($countones(b) % 2 == 1);
            else                       exp_tx[i] = 1'b1;
        end
        exp_fd   = 44'd1 << (len - 1);
        exp_busy = (44'd1 << len) - 44'd1;
        if (d == 1) par_bit = got_tx[9*CPB + 1];
        check($sformatf("frame_tx_d%0d_%02h", d, b),   {20'd0, got_tx},   {20'd0, exp_tx});
        check($sformatf("frame_fd_d%0d_%02h", d, b),   {20'd0, got_fd},   {20'd0, exp_fd});
        check($sformatf("frame_busy_d%0d_%02h", d, b), {20'd0, got_busy}, {20'd0, exp_busy});
    endtask

    initial begin
        int         w, w1, snap, snap1;
        logic       bw, bw1, pb, pb1, bad;
        logic [7:0] r0, r1;

        rst_n = 1'b0;
        tx_en = 1'b0;
        idle(3);
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_d%0d", d), {60'd0, tx_w[d], busy_w[d], rd_w[d], fd_w[d]}, 64'h8);
        rst_n = 1'b1;
        idle(2);
        check("idle_after_reset", {60'd0, tx_w[0], busy_w[0], rd_w[0], fd_w[0]}, 64'h8);

        // Single frame, no parity
        snap = rd_cnt[0];
        tx_en = 1'b1;
        push(0, 8'hA5);
        capture(0, 8'hA5, -1, -1, w, bw, pb);
        check("t1_latency", w, 3);
        idle(3);
        check("t1_pops", rd_cnt[0] - snap, 1);

        // Even parity
        snap1 = rd_cnt[1];
        push(1, 8'h07);
        capture(1, 8'h07, -1, -1, w, bw, pb);
        check("t2_par_07", {63'd0, pb}, 64'd1);
        push(1, 8'h03);
        capture(1, 8'h03, -1, -1, w, bw, pb);
        check("t2_par_03", {63'd0, pb}, 64'd0);
        idle(3);
        check("t2_pops", rd_cnt[1] - snap1, 2);

        // Back-to-back frames with a 2-cycle fetch gap
        snap = rd_cnt[0];
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        capture(0, 8'h11, -1, -1, w, bw, pb);
        check("t3_wait_1", w, 3);
        capture(0, 8'h22, -1, -1, w, bw, pb);
        check("t3_gap_2", w, 3);
        check("t3_busy_gap_2", {63'd0, bw}, 64'd1);
        capture(0, 8'h33, -1, -1, w, bw, pb);
        check("t3_gap_3", w, 3);
        check("t3_busy_gap_3", {63'd0, bw}, 64'd1);
        @(negedge clk);
        check("t3_busy_after", {63'd0, busy_w[0]}, 64'd0);
        idle(2);
        check("t3_pops", rd_cnt[0] - snap, 3);

        // Empty FIFO with tx_en high
        snap = rd_cnt[0];
        snap1 = rd_cnt[1];
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                if (rd_w[d] !== 1'b0 || tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0) bad = 1'b1;
        end
        check("t4_quiet", {63'd0, bad}, 64'd0);
        check("t4_pops", (rd_cnt[0] - snap) + (rd_cnt[1] - snap1), 0);

        // tx_en dropped mid-frame
        snap = rd_cnt[0];
        push(0, 8'h5A); push(0, 8'h6B);
        capture(0, 8'h5A, 10, -1, w, bw, pb);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad = 1'b1;
        end
        check("t5_held_idle", {63'd0, bad}, 64'd0);
        check("t5_pops", rd_cnt[0] - snap, 1);
        tx_en = 1'b1;
        @(negedge clk);
        check("t5_fetch_resume", {63'd0, rd_w[0]}, 64'd1);
        capture(0, 8'h6B, -1, -1, w, bw, pb);
        check("t5_resume_wait", w, 2);

        // Reset during the third data bit
        idle(3);
        snap = rd_cnt[0];
        push(0, 8'hC3); push(0, 8'h96);
        capture(0, 8'hC3, -1, 3*CPB + 1, w, bw, pb);
        capture(0, 8'h96, -1, -1, w, bw, pb);
        check("t6_after_reset_wait", w, 3);
        idle(3);
        check("t6_pops", rd_cnt[0] - snap, 2);

        // Random bytes through both instances in parallel
        for (int it = 0; it < 6; it++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            push(0, r0);
            push(1, r1);
            fork
                capture(0, r0, -1, -1, w, bw, pb);
                capture(1, r1, -1, -1, w1, bw1, pb1);
            join
            check("rand_wait_d0", w, 3);
            check("rand_wait_d1", w1, 3);
        end
        for (int it = 0; it < 3; it++) push(1, 8'($urandom));
        for (int it = 0; it < 3; it++)
            capture(1, mem[1][8'(pushed[1] - 3 + it)], -1, -1, w, bw, pb);

        idle(5);
        check("no_underflow", {62'd0, underflow[0], underflow[1]}, 64'd0);
        check("all_popped_d0", rd_cnt[0], pushed[0]);
        check("all_popped_d1", rd_cnt[1], pushed[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the team's synchronous FIFO. It pops bytes from the FIFO read port whenever the FIFO is non-empty and serialises each byte onto an asynchronous UART line: start bit, DATA_WIDTH data bits LSB first, optional even parity, then stop bit(s). It is the transmit back end of the FIFO-buffered serial path.

Parameters:
DATA_WIDTH, 8, word width; must equal the upstream FIFO DATA_WIDTH.
CLKS_PER_BIT, 16, clk cycles per UART bit; minimum 2.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  synchronous, active-low reset.
tx_en  in  1  1 = new frames may start; 0 = finish the current frame, then hold idle.
fifo_empty  in  1  FIFO empty flag.
fifo_data  in  DATA_WIDTH  FIFO data_out; registered, valid the cycle after a read.
fifo_rd_en  out  1  FIFO read strobe; one-cycle pulse per byte.
tx  out  1  serial line; idles high; registered.
busy  out  1  high from FETCH through the last stop-bit cycle.
frame_done  out  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, bit counter=0, shift register=0. Reset applies mid-frame: the next cycle tx=1, the frame is abandoned, and no further pop is issued.
- States: IDLE, FETCH, LATCH, START, DATA, PARITY, STOP.
- IDLE: tx=1. If tx_en=1 and fifo_empty=0, go to FETCH.
- FETCH: exactly one cycle with fifo_rd_en=1. Go to LATCH.
- LATCH: capture fifo_data into the shift register and compute parity (XOR of the data bits). Go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles; shift right at the end of each bit.
- PARITY: present only if PARITY_EN=1. tx=parity for CLKS_PER_BIT cycles, so the frame has an even number of ones across data+parity.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses in the last cycle. Next state is FETCH if tx_en=1 and fifo_empty=0 (sampled in that last cycle), else IDLE.
- Latency: if IDLE samples fifo_empty=0 at edge t, then FETCH is in cycle t+1 and LATCH in t+2. tx goes 0 in cycle t+3.
- Frame length: (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, counted from the first START cycle.
- Back-to-back frames: the gap between the last stop-bit cycle and the next start bit is exactly 2 cycles of tx=1 (FETCH, LATCH).
- fifo_rd_en is never asserted while fifo_empty=1. At most one pop per frame.
- The bit counter is $clog2(CLKS_PER_BIT) bits wide and wraps at CLKS_PER_BIT-1. The data-bit index is $clog2(DATA_WIDTH)+1 bits wide.
- tx_en falling mid-frame does not truncate the frame; it only blocks the next FETCH.
- fifo_data changes outside LATCH are ignored.

Decomposition:
- Package fifo_uart_pkg:
  - state enum (IDLE..STOP, 3-bit encoding);
  - localparam function for the counter width;
  - legal STOP_BITS values.
- One sub-module, uart_bit_timer:
  - cycle counter with clear and enable;
  - outputs bit_tick in the last cycle of each bit period;
  - the FSM instantiates it once.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0; push 0xA5 into the FIFO -> one fifo_rd_en pulse. tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles. frame_done pulses once, in cycle 40 of the frame.
2. PARITY_EN=1; send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Total frame is 44 cycles at CLKS_PER_BIT=4.
3. Push 0x11, 0x22, 0x33 back-to-back -> three pops and three frames. Each inter-frame tx-high gap is exactly 4 (stop) + 2 cycles. busy stays high until the third frame_done.
4. FIFO empty with tx_en=1 for 100 cycles -> fifo_rd_en never asserted, tx=1, busy=0.
5. Drop tx_en during the DATA bits of 0x5A with 0x6B still queued -> 0x5A completes and 0x6B is not popped. Re-raising tx_en yields a FETCH within 1 cycle.
6. Assert rst_n=0 for 1 cycle during the 3rd data bit -> the next cycle tx=1, busy=0, state IDLE. The next queued byte is then sent as a complete, correct frame.
